cam_window_buffer: RTL and testbench



---
 rtl/cam_buf_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 40 ++++
 rtl/cam_window_buffer.sv | 137 +++++++++++++
 tb/tb_cam_window_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cam_buf_pkg.sv
// cam_buf_pkg: bus codes, register map, FSM encoding and bit indices for cam_window_buffer
package cam_buf_pkg;
  localparam logic [2:0] CMD_WR = 3'b001;
  localparam logic [2:0] CMD_RD = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA = 2'b01;
  localparam logic [6:0] A_FIFO = 7'h00;
  localparam logic [6:0] A_CTRL = 7'h10;
  localparam logic [6:0] A_STAT = 7'h14;
  localparam logic [6:0] A_LS = 7'h20;
  localparam logic [6:0] A_LC = 7'h24;
  localparam logic [6:0] A_PS = 7'h28;
  localparam logic [6:0] A_PC = 7'h2C;
  localparam logic [6:0] A_DEC = 7'h30;
  localparam logic [6:0] A_LVL = 7'h34;
  localparam logic [6:0] A_FRM = 7'h38;
  typedef enum logic [2:0] {
    IDLE = 3'd0, ARMED = 3'd1, WAIT_WIN = 3'd2, CAPTURE = 3'd3, DONE = 3'd4
  } state_t;
  localparam int C_START = 0;
  localparam int C_CONT = 1;
  localparam int C_ABORT = 2;
  localparam int C_IRQEN = 3;
  localparam int ST_CEND = 0;
  localparam int ST_OVF = 4;
  localparam int ST_UDF = 5;
  // true when offset is a multiple of 2^n (n <= 3)
  function automatic logic dec_ok(input logic [2:0] off, input logic [1:0] n);
    return (off & ~(3'b111 << n)) == 3'b000;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with exact fill level and flush
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_W-1:0]     i_data,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] r_wp, r_rp;
  logic w_pop, w_push;
  assign o_level = r_wp - r_rp;
  assign o_empty = o_level == '0;
  assign o_full = o_level[DEPTH_LOG2];
  assign w_pop = i_pop && !o_empty;
  // a pop frees the slot, so a push into a full FIFO still lands
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;
  assign o_data = o_empty ? '0 : r_mem[r_rp[DEPTH_LOG2-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[DEPTH_LOG2-1:0]] <= i_data;
endmodule

// File: rtl/cam_window_buffer.sv
// cam_window_buffer: windowed, decimating camera capture into a FIFO drained over the register bus
module cam_window_buffer
  import cam_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LINE_W = 10,
  parameter int PIX_W = 11,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [DATA_W-1:0] DATA,
  input  logic [2:0]        MCmd,
  input  logic [7:0]        MAddr,
  input  logic [15:0]       MData,
  output logic              SCmdAccept,
  output logic [15:0]       SData,
  output logic [1:0]        SResp,
  output logic              irq
);
  logic [6:0] w_addr;
  logic w_wr, w_rd, w_w1c, w_abort, w_pop, w_pop_ok, w_unused;
  logic r_vs, r_vs_d, r_hr, r_hr_d, r_seen, w_seen, w_fs, w_hrise;
  logic [DATA_W-1:0] r_data, w_head;
  logic [LINE_W-1:0] r_line, w_line, r_ls, r_lc;
  logic [PIX_W-1:0] r_pix, w_pix, r_ps, r_pc;
  logic [1:0] r_hdec, r_vdec;
  logic r_start, r_cont, r_irq_en, r_busy, r_cend, r_ovf, r_udf, r_fs_pend;
  logic [15:0] r_frames, w_rdata;
  logic w_line_in, w_pix_in, w_line_past, w_push, w_kick, w_done, w_empty, w_full;
  logic [DEPTH_LOG2:0] w_level;
  state_t r_st, w_nxt;
  assign SCmdAccept = 1'b1;
  assign irq = r_cend && r_irq_en;
  assign w_unused = ^{MAddr[7], MData};
  assign w_addr = MAddr[6:0];
  assign w_wr = MCmd == CMD_WR;
  assign w_rd = MCmd == CMD_RD;
  assign w_w1c = w_wr && w_addr == A_STAT;
  assign w_abort = w_wr && w_addr == A_CTRL && MData[C_ABORT];
  assign w_pop = w_rd && w_addr == A_FIFO;
  assign w_pop_ok = w_pop && !w_empty;
  assign w_fs = r_vs && !r_vs_d;
  assign w_hrise = r_hr && !r_hr_d;
  // current line/pixel index of the retimed pixel; r_seen marks that line 0 has begun
  assign w_seen = r_seen || w_hrise;
  assign w_line = w_hrise ? (r_seen ? r_line + 1'b1 : '0) : r_line;
  assign w_pix = w_hrise ? '0 : r_pix;
  assign w_line_in = w_seen && w_line >= r_ls && {1'b0, w_line} < {1'b0, r_ls} + {1'b0, r_lc}
                     && dec_ok(3'(w_line - r_ls), r_vdec);
  assign w_line_past = w_seen && {1'b0, w_line} >= {1'b0, r_ls} + {1'b0, r_lc};
  assign w_pix_in = w_pix >= r_ps && {1'b0, w_pix} < {1'b0, r_ps} + {1'b0, r_pc}
                    && dec_ok(3'(w_pix - r_ps), r_hdec);
  assign w_push = (r_st == WAIT_WIN || r_st == CAPTURE) && r_hr && w_line_in && w_pix_in;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk), .reset_n(reset_n), .i_flush(w_abort), .i_push(w_push), .i_pop(w_pop),
    .i_data(r_data), .o_data(w_head), .o_empty(w_empty), .o_full(w_full), .o_level(w_level)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_st <= IDLE;
    else r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    w_kick = 1'b0;
    w_done = 1'b0;
    case (r_st)
      IDLE: w_nxt = r_start ? ARMED : IDLE;
      ARMED: begin
        w_kick = w_fs || r_fs_pend;
        w_nxt = w_kick ? WAIT_WIN : ARMED;
      end
      WAIT_WIN: w_nxt = w_fs ? DONE : w_line_in ? CAPTURE : WAIT_WIN;
      CAPTURE: w_nxt = (w_fs || w_line_past) ? DONE : CAPTURE;
      DONE: begin
        w_done = 1'b1;
        w_nxt = r_cont ? ARMED : IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      A_FIFO: w_rdata = 16'(w_head);
      A_CTRL: w_rdata = 16'({r_irq_en, 1'b0, r_cont, r_start});
      A_STAT: w_rdata = 16'({r_udf, r_ovf, w_full, w_empty, r_busy, r_cend});
      A_LS: w_rdata = 16'(r_ls);
      A_LC: w_rdata = 16'(r_lc);
      A_PS: w_rdata = 16'(r_ps);
      A_PC: w_rdata = 16'(r_pc);
      A_DEC: w_rdata = 16'({r_vdec, r_hdec});
      A_LVL: w_rdata = 16'(w_level);
      A_FRM: w_rdata = r_frames;
      default: w_rdata = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {r_vs, r_vs_d, r_hr, r_hr_d, r_seen, r_fs_pend} <= '0;
      {r_start, r_cont, r_irq_en, r_busy, r_cend, r_ovf, r_udf} <= '0;
      r_data <= '0;
      r_line <= '0;
      r_pix <= '0;
      {r_ls, r_lc, r_ps, r_pc, r_hdec, r_vdec} <= '0;
      r_frames <= '0;
      SData <= '0;
      SResp <= RESP_NULL;
    end else begin
      r_vs <= VSYNC;
      r_vs_d <= r_vs;
      r_hr <= HREF;
      r_hr_d <= r_hr;
      r_data <= DATA;
      r_line <= w_fs ? '0 : w_line;
      r_seen <= w_fs ? w_hrise : w_seen;
      if (r_hr) r_pix <= w_pix + 1'b1;
      // remembers a frame_start that ended the previous capture so continuous mode skips nothing
      r_fs_pend <= (w_abort || r_st == IDLE || w_kick) ? 1'b0 : (r_fs_pend || w_fs);
      if (w_wr && w_addr == A_LS) r_ls <= MData[LINE_W-1:0];
      if (w_wr && w_addr == A_LC) r_lc <= MData[LINE_W-1:0];
      if (w_wr && w_addr == A_PS) r_ps <= MData[PIX_W-1:0];
      if (w_wr && w_addr == A_PC) r_pc <= MData[PIX_W-1:0];
      if (w_wr && w_addr == A_DEC) {r_vdec, r_hdec} <= MData[3:0];
      if (w_wr && w_addr == A_CTRL) {r_irq_en, r_cont} <= {MData[C_IRQEN], MData[C_CONT]};
      r_start <= w_abort ? 1'b0 : (w_wr && w_addr == A_CTRL) ? MData[C_START] : w_kick ? 1'b0 : r_start;
      r_busy <= w_abort ? 1'b0 : w_kick ? 1'b1 : (w_done && !r_cont) ? 1'b0 : r_busy;
      r_cend <= w_done || (r_cend && !(w_w1c && MData[ST_CEND]));
      r_ovf <= (w_push && w_full && !w_pop_ok && !w_abort) || (r_ovf && !(w_w1c && MData[ST_OVF]));
      r_udf <= (w_pop && w_empty) || (r_udf && !(w_w1c && MData[ST_UDF]));
      if (w_done) r_frames <= r_frames + 1'b1;
      SResp <= w_rd ? RESP_DVA : RESP_NULL;
      SData <= w_rd ? w_rdata : '0;
    end
endmodule

// File: tb/tb_cam_window_buffer.sv
// tb_cam_window_buffer: directed camera frames and register reads checked through a response scoreboard
module tb_cam_window_buffer;
  import cam_buf_pkg::*;
  localparam int DW = 8;
  typedef struct {
    logic [6:0] a;
    logic [15:0] d;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, VSYNC = 1'b0, HREF = 1'b0;
  logic [DW-1:0] DATA = '0;
  logic [2:0] MCmd = 3'b000;
  logic [7:0] MAddr = '0;
  logic [15:0] MData = '0;
  logic SCmdAccept, irq;
  logic [15:0] SData;
  logic [1:0] SResp;
  exp_t q[$];
  exp_t m_e;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  cam_window_buffer #(.DATA_W(DW), .LINE_W(10), .PIX_W(11), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
    .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .SCmdAccept(SCmdAccept),
    .SData(SData), .SResp(SResp), .irq(irq)
  );
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", name, got, exp);
    end
  endtask
  always @(negedge clk)
    if (reset_n && SResp != RESP_NULL) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_resp: got SResp %0b SData %04h expected no response", SResp, SData);
      end else begin
        m_e = q.pop_front();
        check($sformatf("rd_%02h", m_e.a), SData, m_e.d);
      end
    end
  task automatic wr(input logic [6:0] aa, input logic [15:0] dd);
    MCmd = CMD_WR;
    MAddr = {1'b0, aa};
    MData = dd;
    @(negedge clk);
    MCmd = 3'b000;
  endtask
  task automatic rd(input logic [6:0] aa, input logic [15:0] dd);
    exp_t e;
    e.a = aa;
    e.d = dd;
    q.push_back(e);
    MCmd = CMD_RD;
    MAddr = {1'b0, aa};
    @(negedge clk);
    MCmd = 3'b000;
  endtask
  task automatic vsync_pulse();
    VSYNC = 1'b1;
    repeat (2) @(negedge clk);
    VSYNC = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic line(input int np);
    for (int p = 0; p < np; p++) begin
      HREF = 1'b1;
      DATA = DW'(p);
      @(negedge clk);
    end
    HREF = 1'b0;
    DATA = '0;
    repeat (4) @(negedge clk);
  endtask
  task automatic frame(input int nl, input int np);
    vsync_pulse();
    for (int l = 0; l < nl; l++) line(np);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_sdata", SData, 16'h0000);
    check("reset_sresp", 16'(SResp), 16'h0000);
    check("reset_irq", 16'(irq), 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    rd(A_STAT, 16'h0004);
    rd(A_CTRL, 16'h0000);
    rd(A_LVL, 16'h0000);
    rd(A_FRM, 16'h0000);
    rd(7'h3C, 16'h0000);
    // single shot: lines 10..11, pixels 4..11
    wr(A_LS, 16'd10);
    wr(A_LC, 16'd2);
    wr(A_PS, 16'd4);
    wr(A_PC, 16'd8);
    rd(A_LS, 16'h000A);
    wr(A_CTRL, 16'h0001);
    rd(A_CTRL, 16'h0001);
    frame(14, 16);
    rd(A_STAT, 16'h0009);
    rd(A_LVL, 16'h0010);
    rd(A_FRM, 16'h0001);
    rd(A_CTRL, 16'h0000);
    for (int i = 0; i < 16; i++) rd(A_FIFO, 16'(4 + i % 8));
    rd(A_STAT, 16'h0005);
    // decimation by 2 on both axes
    wr(A_DEC, 16'h0005);
    wr(A_LC, 16'd4);
    rd(A_DEC, 16'h0005);
    wr(A_CTRL, 16'h0001);
    frame(16, 16);
    rd(A_LVL, 16'h0008);
    rd(A_FRM, 16'h0002);
    for (int i = 0; i < 8; i++) rd(A_FIFO, 16'(4 + 2 * (i % 4)));
    // continuous: window on the last line, so each capture ends at the next frame_start
    wr(A_STAT, 16'h0001);
    wr(A_LS, 16'd2);
    wr(A_LC, 16'd1);
    wr(A_PS, 16'd3);
    wr(A_PC, 16'd4);
    wr(A_DEC, 16'h0000);
    wr(A_CTRL, 16'h0003);
    repeat (3) frame(3, 10);
    frame(0, 0);
    rd(A_STAT, 16'h0003);
    rd(A_LVL, 16'h000C);
    rd(A_FRM, 16'h0005);
    for (int i = 0; i < 12; i++) rd(A_FIFO, 16'(3 + i % 4));
    wr(A_CTRL, 16'h0004);
    rd(A_STAT, 16'h0005);
    rd(A_CTRL, 16'h0000);
    // overflow: 20 pixels into 16 entries
    wr(A_STAT, 16'h003F);
    wr(A_LS, 16'd1);
    wr(A_PS, 16'd0);
    wr(A_PC, 16'd20);
    wr(A_CTRL, 16'h0001);
    frame(3, 24);
    rd(A_STAT, 16'h0019);
    rd(A_LVL, 16'h0010);
    for (int i = 0; i < 16; i++) rd(A_FIFO, 16'(i));
    rd(A_FRM, 16'h0006);
    // underflow and its W1C
    rd(A_FIFO, 16'h0000);
    rd(A_STAT, 16'h0035);
    wr(A_STAT, 16'h0020);
    rd(A_STAT, 16'h0015);
    // irq level and abort mid-capture
    wr(A_CTRL, 16'h0008);
    check("irq_set", 16'(irq), 16'h0001);
    wr(A_STAT, 16'h003F);
    check("irq_clr", 16'(irq), 16'h0000);
    wr(A_LC, 16'd2);
    wr(A_PC, 16'd8);
    wr(A_CTRL, 16'h0009);
    vsync_pulse();
    line(10);
    for (int p = 0; p < 6; p++) begin
      HREF = 1'b1;
      DATA = DW'(p);
      @(negedge clk);
    end
    wr(A_CTRL, 16'h000C);
    HREF = 1'b0;
    rd(A_STAT, 16'h0004);
    rd(A_LVL, 16'h0000);
    rd(A_CTRL, 16'h0008);
    rd(A_FRM, 16'h0006);
    wr(A_CTRL, 16'h0005);
    rd(A_CTRL, 16'h0000);
    rd(A_STAT, 16'h0004);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
